// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the core datapath and the word-organised data RAM.
// A request is decoded and latched in IDLE. Legal requests spend one cycle in ACCESS
// driving the RAM, then present a response in RESP. Rejected requests skip ACCESS and
// never touch the RAM. Load data is lane-selected and extended from ram_rdata_i while
// in RESP; the RAM output is stable there because chip select stays high.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | ready for a request; decode and latch on req_valid_i
//   ST_ACCESS | one-cycle RAM access with the registered address/mask/data
//   ST_RESP   | response presented and held until resp_ready_i

`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module mem_lsu #(
    parameter int RAM_AW = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [`API_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]                 req_size_i,
    input  logic                       req_unsigned_i,
    input  logic [`API_DATA_WIDTH-1:0] req_wdata_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [`API_DATA_WIDTH-1:0] resp_rdata_o,
    output logic                       resp_err_o,
    output logic                       ram_en_n_o,
    output logic [`API_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [`API_DATA_WIDTH-1:0] ram_wdata_o,
    output logic [3:0]                 ram_wr_mask_o,
    input  logic [`API_DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int AW = `API_ADDR_WIDTH;
    localparam int DW = `API_DATA_WIDTH;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;

    // latched request attributes
    logic            r_we;
    logic            r_unsigned;
    logic            r_err;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic [3:0]      r_mask;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;

    // request decode
    logic            w_range_err;
    logic            w_req_err;
    logic [3:0]      w_req_mask;
    logic [DW-1:0]   w_req_wdata;
    logic [AW-1:0]   w_word_addr;

    // load extraction
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic [DW-1:0]   w_ld_ext;

    // Decode the incoming request: error check, byte mask, lane replication, word address.
    always_comb begin
        w_range_err = |(req_addr_i >> (RAM_AW + 2));
        w_req_err   = w_range_err;
        w_req_mask  = 4'b0000;
        w_req_wdata = req_wdata_i;
        w_word_addr = '0;
        w_word_addr[RAM_AW-1:0] = req_addr_i[RAM_AW+1:2];

        case (req_size_i)
            SZ_BYTE: begin
                w_req_mask  = 4'b0001 << req_addr_i[1:0];
                w_req_wdata = {4{req_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_req_err   = w_range_err | req_addr_i[0];
                w_req_mask  = req_addr_i[1] ? 4'b1100 : 4'b0011;
                w_req_wdata = {2{req_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                w_req_err   = w_range_err | (req_addr_i[1:0] != 2'b00);
                w_req_mask  = 4'b1111;
                w_req_wdata = req_wdata_i;
            end
            default: begin
                w_req_err   = 1'b1;
            end
        endcase

        // loads never assert a write lane
        if (!req_we_i) begin
            w_req_mask = 4'b0000;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake/RAM control outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        resp_err_o    = 1'b0;
        resp_rdata_o  = '0;
        ram_en_n_o    = 1'b1;
        ram_wr_mask_o = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // reset cancels an access still in flight so a dropped store cannot land
                ram_en_n_o    = reset;
                ram_wr_mask_o = reset ? 4'b0000 : r_mask;
                w_state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = r_err;
                resp_rdata_o = (r_err || r_we) ? '0 : w_ld_ext;
                if (resp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch request attributes on accept; RAM-facing registers only change for legal requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_lane      <= 2'b00;
            r_mask      <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_accept) begin
            r_we       <= req_we_i;
            r_unsigned <= req_unsigned_i;
            r_err      <= w_req_err;
            r_size     <= req_size_i;
            r_lane     <= req_addr_i[1:0];
            if (!w_req_err) begin
                r_mask      <= w_req_mask;
                r_ram_addr  <= w_word_addr;
                r_ram_wdata <= w_req_wdata;
            end
        end
    end

    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;

    // Select the addressed lane of the returned word and extend it to full width.
    always_comb begin
        w_ld_byte = ram_rdata_i[{r_lane, 3'b000} +: 8];
        w_ld_half = r_lane[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
        case (r_size)
            SZ_BYTE: w_ld_ext = {{(DW-8){~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: w_ld_ext = {{(DW-16){~r_unsigned & w_ld_half[15]}}, w_ld_half};
            default: w_ld_ext = ram_rdata_i;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a word RAM model answers the DUT, and a byte-array reference
// memory predicts every response from the load/store rules.

`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_we_i, req_unsigned_i, resp_ready_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_ready_o, resp_valid_o, resp_err_o, ram_en_n_o;
    logic [31:0] resp_rdata_o, ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_wr_mask_o;
    logic [31:0] ram_rdata_i = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_lsu #(.RAM_AW(14)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .ram_en_n_o(ram_en_n_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_wr_mask_o(ram_wr_mask_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    // word RAM: acts on the posedge that samples en_n low
    bit [31:0] ram [0:16383];
    int        ram_wr_cnt = 0;
    always @(posedge clk) begin
        if (ram_en_n_o === 1'b0) begin
            if (ram_wr_mask_o != 4'b0000) ram_wr_cnt <= ram_wr_cnt + 1;
            for (int k = 0; k < 4; k++)
                if (ram_wr_mask_o[k]) ram[ram_addr_o[13:0]][8*k +: 8] <= ram_wdata_o[8*k +: 8];
            ram_rdata_i <= ram[ram_addr_o[13:0]];
        end
    end

    // byte-addressed reference memory
    bit [7:0] ref_mem [0:65535];

    function automatic bit ref_err(input logic [31:0] a, input int sz);
        return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a >= 32'd65536);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int sz, input bit uns);
        logic [31:0] v;
        int n;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + i] = d[8*i +: 8];
    endtask

    function automatic logic [3:0] ref_mask(input logic [31:0] a, input int sz);
        return 4'(((1 << (1 << sz)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_rep(input logic [31:0] d, input int sz);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % (1 << sz)) +: 8];
        return r;
    endfunction

    // Drive one request and follow it to the response; hold the response for `hold` cycles,
    // optionally with another request pending, reporting what was seen.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata, input int hold, input bit pend,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int en_cnt, output logic [31:0] en_addr, output logic [3:0] en_mask,
                          output logic [31:0] en_wdata, output bit stable_ok, output bit blocked_ok);
        int w;
        @(negedge clk);
        req_we_i = we; req_addr_i = addr; req_size_i = size;
        req_unsigned_i = uns; req_wdata_i = wdata; req_valid_i = 1'b1;
        w = 0;
        while (req_ready_o !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL req_ready_timeout: ready=%b required 1", req_ready_o);
        end
        @(posedge clk);
        lat = 0; en_cnt = 0; en_addr = 'x; en_mask = 'x; en_wdata = 'x;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid_i = 1'b0;
            if (ram_en_n_o === 1'b0) begin
                en_cnt++; en_addr = ram_addr_o; en_mask = ram_wr_mask_o; en_wdata = ram_wdata_o;
            end
        end while (resp_valid_o !== 1'b1 && lat < 20);
        rdata = resp_rdata_o; err = resp_err_o;
        stable_ok = 1'b1; blocked_ok = 1'b1;
        if (pend) begin
            req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h44; req_size_i = 2'd2;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== rdata || resp_err_o !== err) stable_ok = 1'b0;
            if (req_ready_o !== 1'b0 || ram_en_n_o !== 1'b1) blocked_ok = 1'b0;
            if (ram_en_n_o === 1'b0) en_cnt++;
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_size_i = 0;
        req_unsigned_i = 0; req_wdata_i = 0; resp_ready_i = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b exp 1", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid_o); end
        n_cmp++; if (resp_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", resp_err_o); end
        n_cmp++; if (resp_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h exp 0", resp_rdata_o); end
        n_cmp++; if (ram_en_n_o !== 1'b1) begin n_bad++; $display("FAIL rst_en_n: got %b exp 1", ram_en_n_o); end
        n_cmp++; if (ram_wr_mask_o !== 4'h0) begin n_bad++; $display("FAIL rst_mask: got %h exp 0", ram_wr_mask_o); end
        n_cmp++; if (ram_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h exp 0", ram_addr_o); end
        n_cmp++; if (ram_wdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h exp 0", ram_wdata_o); end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_mask;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
    } op_t;

    task automatic test_directed;
        op_t tbl[8];
        logic [31:0] rd, ea, ew; logic er; logic [3:0] em; int lat, ec; bit st, bl;
        tbl[0] = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        4'hF, 32'h4, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 4'h0, 32'h4, 32'h0};
        tbl[2] = '{1'b1, 32'h13, 2'd0, 1'b0, 32'h80,       32'h0,        4'h8, 32'h4, 32'h80808080};
        tbl[3] = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 4'h0, 32'h4, 32'h0};
        tbl[4] = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        32'h00000080, 4'h0, 32'h4, 32'h0};
        tbl[5] = '{1'b1, 32'h22, 2'd1, 1'b0, 32'h8001,     32'h0,        4'hC, 32'h8, 32'h80018001};
        tbl[6] = '{1'b0, 32'h22, 2'd1, 1'b0, 32'h0,        32'hFFFF8001, 4'h0, 32'h8, 32'h0};
        tbl[7] = '{1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        32'h80010000, 4'h0, 32'h8, 32'h0};
        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata, 0, 0,
                   rd, er, lat, ec, ea, em, ew, st, bl);
            if (tbl[i].we) ref_store(tbl[i].addr, int'(tbl[i].size), tbl[i].wdata);
            n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL dir_err[%0d]: got %b exp 0", i, er); end
            n_cmp++; if (rd !== tbl[i].exp_rdata) begin n_bad++; $display("FAIL dir_rdata[%0d]: got %h exp %h", i, rd, tbl[i].exp_rdata); end
            n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d exp 2", i, lat); end
            n_cmp++; if (ec !== 1) begin n_bad++; $display("FAIL dir_en_pulses[%0d]: got %0d exp 1", i, ec); end
            n_cmp++; if (ea !== tbl[i].exp_waddr) begin n_bad++; $display("FAIL dir_ram_addr[%0d]: got %h exp %h", i, ea, tbl[i].exp_waddr); end
            n_cmp++; if (em !== tbl[i].exp_mask) begin n_bad++; $display("FAIL dir_mask[%0d]: got %h exp %h", i, em, tbl[i].exp_mask); end
            if (tbl[i].we) begin
                n_cmp++; if (ew !== tbl[i].exp_wdata) begin n_bad++; $display("FAIL dir_wdata[%0d]: got %h exp %h", i, ew, tbl[i].exp_wdata); end
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs[4] = '{32'h21, 32'h1E, 32'h0, 32'h10000};
        logic [1:0]  sizes[4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] rd, ea, ew; logic er; logic [3:0] em; int lat, ec, wc; bit st, bl;
        for (int i = 0; i < 4; i++) begin
            wc = ram_wr_cnt;
            do_req(1'($urandom_range(1)), addrs[i], sizes[i], 1'b0, $urandom, 0, 0,
                   rd, er, lat, ec, ea, em, ew, st, bl);
            n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_flag[%0d]: got %b exp 1", i, er); end
            n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL err_rdata[%0d]: got %h exp 0", i, rd); end
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL err_latency[%0d]: got %0d exp 1", i, lat); end
            n_cmp++; if (ec !== 0 || ram_wr_cnt !== wc) begin n_bad++; $display("FAIL err_ram_touch[%0d]: got %0d pulses exp 0", i, ec); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, ea, ew, d; logic er; logic [3:0] em; int lat, ec; bit st, bl;
        d = $urandom;
        do_req(1'b1, 32'h40, 2'd2, 1'b0, d, 5, 1, rd, er, lat, ec, ea, em, ew, st, bl);
        ref_store(32'h40, 2, d);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_store_stable: got %b exp 1", st); end
        n_cmp++; if (bl !== 1'b1) begin n_bad++; $display("FAIL bp_store_blocked: got %b exp 1", bl); end
        n_cmp++; if (ec !== 1) begin n_bad++; $display("FAIL bp_store_pulses: got %0d exp 1", ec); end
        do_req(1'b0, 32'h42, 2'd1, 1'b0, 32'h0, 5, 1, rd, er, lat, ec, ea, em, ew, st, bl);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL bp_load_stable: got %b exp 1", st); end
        n_cmp++; if (bl !== 1'b1) begin n_bad++; $display("FAIL bp_load_blocked: got %b exp 1", bl); end
        n_cmp++; if (rd !== ref_load(32'h42, 1, 1'b0)) begin n_bad++; $display("FAIL bp_load_rdata: got %h exp %h", rd, ref_load(32'h42, 1, 1'b0)); end
        n_cmp++; if (ec !== 1) begin n_bad++; $display("FAIL bp_load_pulses: got %0d exp 1", ec); end
    endtask

    task automatic test_random;
        logic [31:0] rd, ea, ew, a, d, exp_rd; logic er; logic [3:0] em; int lat, ec, sz; bit st, bl, we, uns, xe;
        for (int i = 0; i < 80; i++) begin
            sz = $urandom_range(3);
            we = 1'($urandom_range(1)); uns = 1'($urandom_range(1)); d = $urandom;
            if ($urandom_range(7) == 0) a = $urandom;
            else a = 32'h100 + $urandom_range(63);
            if ($urandom_range(9) < 7 && sz < 3) a = a & ~((32'd1 << sz) - 1);
            xe = ref_err(a, sz);
            exp_rd = (xe || we) ? 32'h0 : ref_load(a, sz, uns);
            do_req(we, a, 2'(sz), uns, d, $urandom_range(2), 0, rd, er, lat, ec, ea, em, ew, st, bl);
            if (!xe && we) ref_store(a, sz, d);
            n_cmp++; if (er !== xe) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b exp %b (a=%h sz=%0d)", i, er, xe, a, sz); end
            n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h exp %h (a=%h sz=%0d)", i, rd, exp_rd, a, sz); end
            n_cmp++; if (lat !== (xe ? 1 : 2)) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", i, lat, xe ? 1 : 2); end
            n_cmp++; if (ec !== (xe ? 0 : 1)) begin n_bad++; $display("FAIL rnd_pulses[%0d]: got %0d exp %0d", i, ec, xe ? 0 : 1); end
            if (!xe) begin
                n_cmp++; if (ea !== (a >> 2)) begin n_bad++; $display("FAIL rnd_ram_addr[%0d]: got %h exp %h", i, ea, a >> 2); end
                n_cmp++; if (em !== (we ? ref_mask(a, sz) : 4'h0)) begin n_bad++; $display("FAIL rnd_mask[%0d]: got %h exp %h", i, em, we ? ref_mask(a, sz) : 4'h0); end
                if (we) begin
                    n_cmp++; if (ew !== ref_rep(d, sz)) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", i, ew, ref_rep(d, sz)); end
                end
            end
        end
    endtask

    task automatic test_reset_access;
        logic [31:0] rd, ea, ew; logic er; logic [3:0] em; int lat, ec, wc; bit st, bl;
        @(negedge clk);
        req_we_i = 1'b1; req_addr_i = 32'h80; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_wdata_i = 32'hCAFEF00D; req_valid_i = 1'b1;
        wc = ram_wr_cnt;
        @(posedge clk);
        #1;
        n_cmp++; if (ram_en_n_o !== 1'b0) begin n_bad++; $display("FAIL rsta_in_access: en_n %b exp 0", ram_en_n_o); end
        reset = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram_wr_cnt !== wc) begin n_bad++; $display("FAIL rsta_no_write: writes %0d exp %0d", ram_wr_cnt, wc); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rsta_resp_valid: got %b exp 0", resp_valid_o); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rsta_ready: got %b exp 1", req_ready_o); end
        do_req(1'b0, 32'h80, 2'd2, 1'b0, 32'h0, 0, 0, rd, er, lat, ec, ea, em, ew, st, bl);
        n_cmp++; if (rd !== ref_load(32'h80, 2, 1'b0)) begin n_bad++; $display("FAIL rsta_readback: got %h exp %h", rd, ref_load(32'h80, 2, 1'b0)); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_errors;
        test_backpressure;
        test_random;
        test_reset_access;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
